uart_rx_fifo: RTL and testbench

- UART receiver (8N1, LSB first) with a small receive FIFO.
- Sits between the UART_RX pin and the HACK memory-mapped UART register.
- The CPU reads the head byte plus status flags on `out`, then pulses `clear` to pop the byte.
- Replaces the single-byte receiver so back-to-back frames are not lost while the CPU is busy.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, status bit layout,
// default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } uart_state_e;

    localparam int unsigned EMPTY_BIT        = 15;
    localparam int unsigned OVR_BIT          = 14;
    localparam int unsigned FERR_BIT         = 13;
    localparam int unsigned DEFAULT_BAUD_DIV = 868;

    // Status word seen by the CPU: flags in the top bits, head byte in the low byte.
    function automatic logic [15:0] pack_status(input logic       empty,
                                                input logic       ovr,
                                                input logic       ferr,
                                                input logic [7:0] data);
        logic [15:0] s;
        s            = '0;
        s[EMPTY_BIT] = empty;
        s[OVR_BIT]   = ovr;
        s[FERR_BIT]  = ferr;
        s[7:0]       = data;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with an extra pointer MSB to tell full from empty.
// A pop on an empty FIFO is ignored; a push while full is accepted only alongside a real pop.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTX,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop_ok;
    logic w_push_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO; the CPU reads head byte plus sticky
// overrun/framing flags on out and pops with clear.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        rx,
    input  logic        clear,
    output logic [15:0] out,
    output logic        busy
);

    localparam int unsigned     CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    logic [1:0]    r_sync;
    logic          w_rs;
    uart_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_busy;
    logic          r_ovr;
    logic          r_ferr;

    logic          w_stop_sample;
    logic          w_push;
    logic          w_ferr_set;
    logic          w_ovr_set;
    logic          w_empty;
    logic          w_full;
    logic [7:0]    w_dout;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rs = r_sync[1];

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_rs) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rs) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= StData;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rs) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= StBreak;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StBreak: begin
                    // Hold here until the line recovers so a stuck-low line yields no 0x00 frames.
                    if (w_rs) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_stop_sample = (r_state == StStop) && (r_cnt == CNT_LAST);
    assign w_push        = w_stop_sample && w_rs;
    assign w_ferr_set    = w_stop_sample && !w_rs;
    // A full FIFO still accepts the byte when clear pops in the same cycle.
    assign w_ovr_set     = w_push && w_full && !clear;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clear) begin
                r_ovr <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (clear) begin
                r_ferr <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTX  (RSTX),
        .push  (w_push),
        .pop   (clear),
        .din   (r_shift),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign out  = pack_status(w_empty, r_ovr, r_ferr, w_empty ? 8'h00 : w_dout);
    assign busy = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: drives 8N1 frames and compares out/busy against
// a queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;

    localparam int unsigned B     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned H     = B / 2;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        rx = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q [$];
    bit         m_ovr;
    bit         m_ferr;
    logic [7:0] seq5 [5] = '{8'h52, 8'h58, 8'h01, 8'h02, 8'h03};

    uart_rx_fifo #(
        .BAUD_DIV (B),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RSTX  (RSTX),
        .rx    (rx),
        .clear (clear),
        .out   (out),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_out();
        logic [7:0] head;
        head = (m_q.size() == 0) ? 8'h00 : m_q[0];
        return {(m_q.size() == 0), m_ovr, m_ferr, 5'b0, head};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 0;
        m_ferr = 0;
    endtask

    task automatic model_clear();
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_ovr  = 0;
        m_ferr = 0;
    endtask

    // Stop-bit event, optionally coinciding with a clear strobe.
    task automatic model_frame(input logic [7:0] d, input bit stop, input bit clr);
        bit was_full;
        was_full = (m_q.size() == DEPTH);
        if (clr) model_clear();
        if (stop) begin
            if (!was_full || clr) m_q.push_back(d);
            else m_ovr = 1;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic line_idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        @(posedge CLK);
        #1 clear = 1'b1;
        @(posedge CLK);
        #1 clear = 1'b0;
        model_clear();
        check_eq("clear_out", out, exp_out());
    endtask

    // The stop bit is sampled H+3 edges into bit 9 (2 sync flops + IDLE->START edge).
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit clr_stop,
                              input bit abort);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < int'(B); c++) begin
                if (abort && i == 4 && c == 0) begin
                    RSTX = 1'b0;
                    #1;
                    model_reset();
                    check_eq("rst_mid_out", out, 16'h8000);
                    check_eq("rst_mid_busy", {15'b0, busy}, 16'h0000);
                    @(negedge CLK);
                    rx   = 1'b1;
                    RSTX = 1'b1;
                    return;
                end
                if (i == 5 && c == 0) check_eq("busy_mid", {15'b0, busy}, 16'h0001);
                if (i == 9 && c == int'(H) + 2) begin
                    check_eq("pre_push_out", out, exp_out());
                    clear = clr_stop;
                end
                if (i == 9 && c == int'(H) + 3) begin
                    clear = 1'b0;
                    model_frame(d, stop, clr_stop);
                    check_eq("post_push_out", out, exp_out());
                    check_eq("post_push_busy", {15'b0, busy}, {15'b0, !stop});
                end
                @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         busy_cnt;
        logic [7:0] d;
        bit         stop;
        bit         clr;

        model_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check_eq("rst_out", out, 16'h8000);
            check_eq("rst_busy", {15'b0, busy}, 16'h0000);
        end
        @(negedge CLK);
        RSTX = 1'b1;
        line_idle(4);
        check_eq("post_rst_out", out, 16'h8000);

        send_frame(8'h52, 1'b1, 1'b0, 1'b0);
        check_eq("single_out", out, 16'h0052);
        do_clear();
        check_eq("single_cleared", out, 16'h8000);

        foreach (seq5[k]) send_frame(seq5[k], 1'b1, 1'b0, 1'b0);
        check_eq("ovr_out", out, 16'h4052);
        repeat (4) do_clear();
        check_eq("ovr_drained", out, 16'h8000);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (20 * B) @(posedge CLK);
        #1;
        check_eq("break_out", out, 16'hA000);
        check_eq("break_busy", {15'b0, busy}, 16'h0001);
        line_idle(4);
        check_eq("break_exit_busy", {15'b0, busy}, 16'h0000);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        check_eq("after_break_out", out, 16'h2033);
        do_clear();

        line_idle(B);
        busy_cnt = 0;
        rx = 1'b0;
        for (int k = 0; k < 2 * int'(B); k++) begin
            @(posedge CLK);
            #1;
            if (k == int'(H) - 4) rx = 1'b1;
            if (busy) busy_cnt++;
        end
        check_eq("glitch_busy_range",
                 {15'b0, (busy_cnt >= 1 && busy_cnt <= int'(H) + 2)}, 16'h0001);
        check_eq("glitch_out", out, exp_out());

        for (int k = 1; k <= 4; k++) send_frame(8'(8'h10 + k), 1'b1, 1'b0, 1'b0);
        send_frame(8'h15, 1'b1, 1'b1, 1'b0);
        check_eq("full_pop_out", out, 16'h0012);
        repeat (4) do_clear();
        check_eq("full_pop_drained", out, 16'h8000);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0, 1'b1);
        line_idle(B);
        send_frame(8'h6C, 1'b1, 1'b0, 1'b0);
        check_eq("after_rst_frame", out, 16'h006C);
        do_clear();

        for (int k = 0; k < 40; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            clr  = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, clr, 1'b0);
            if (!stop) line_idle(4);
            check_eq("rand_out", out, exp_out());
            if ($urandom_range(0, 2) == 0) do_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
